// File: rtl/btu_pkg.sv
// Shared types and constants for the branch target unit.
package btu_pkg;

    typedef enum logic [1:0] {
        BRANCH = 2'd0,
        JAL    = 2'd1,
        JALR   = 2'd2,
        NONE   = 2'd3
    } op_e;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/btu_ras.sv
// Circular return-address stack: a push on a full stack overwrites the oldest entry.
// push and pop together replace the top entry in place (pop on empty is ignored).
module btu_ras #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   top_idx;
    logic [PW:0]     count;
    logic            do_pop;

    assign top_idx = ptr - 1'b1;
    assign empty   = (count == '0);
    assign top     = mem[top_idx];
    assign do_pop  = pop && !empty;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && do_pop) begin
            ptr   <= ptr;
        end else if (push) begin
            ptr <= ptr + 1'b1;
            if (count != FULL)
                count <= count + 1'b1;
        end else if (do_pop) begin
            ptr   <= top_idx;
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[do_pop ? top_idx : ptr] <= push_data;
    end

endmodule

// File: rtl/branch_target_unit.sv
// One-stage next-PC / link computation with valid-ready handshake.
// Optional return-address stack enabled by defining BTU_RAS_EN.
module branch_target_unit
    import btu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            br_taken,
    input  logic            is_call,
    input  logic            is_ret,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] link,
    output logic            redirect,
    output logic            misaligned,
    output logic [XLEN-1:0] ras_pred,
    output logic            ras_hit
);
    op_e             op_q;
    logic            accept;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] rel_tgt;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] nxt_target;
    logic            nxt_redirect;

    assign op_q     = op_e'(op);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign seq_pc   = pc + XLEN'(INSTR_BYTES);
    assign rel_tgt  = pc + imm;
    assign jalr_sum = rs1 + imm;

    always_comb begin
        nxt_target   = seq_pc;
        nxt_redirect = 1'b0;
        case (op_q)
            BRANCH: begin
                if (br_taken) begin
                    nxt_target   = rel_tgt;
                    nxt_redirect = (rel_tgt != seq_pc);
                end
            end
            JAL: begin
                nxt_target   = rel_tgt;
                nxt_redirect = 1'b1;
            end
            JALR: begin
                nxt_target   = {jalr_sum[XLEN-1:1], 1'b0};
                nxt_redirect = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid  <= 1'b0;
            target     <= '0;
            link       <= '0;
            redirect   <= 1'b0;
            misaligned <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            target     <= nxt_target;
            link       <= seq_pc;
            redirect   <= nxt_redirect;
            misaligned <= |nxt_target[1:0];
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef BTU_RAS_EN
    logic            ras_push;
    logic            ras_pop;
    logic            ras_empty;
    logic [XLEN-1:0] ras_top;

    // Hints only matter on jumps; returns pop only on JALR.
    assign ras_push = accept && is_call && (op_q == JAL || op_q == JALR);
    assign ras_pop  = accept && is_ret && (op_q == JALR);

    btu_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ras_pred <= '0;
            ras_hit  <= 1'b0;
        end else if (accept) begin
            ras_hit  <= ras_pop && !ras_empty;
            ras_pred <= (ras_pop && !ras_empty) ? ras_top : '0;
        end
    end
`else
    localparam int unsigned unused_ras_depth = RAS_DEPTH;
    logic unused_ras_hints;

    assign unused_ras_hints = is_call ^ is_ret;
    assign ras_pred         = '0;
    assign ras_hit          = 1'b0;
`endif

endmodule

// File: tb/tb_branch_target_unit.sv
// Scoreboard bench for branch_target_unit; RAS expectations follow BTU_RAS_EN.
module tb_branch_target_unit;
    import btu_pkg::*;

`ifdef BTU_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] target;
        logic [31:0] link;
        logic        redirect;
        logic        misaligned;
        logic [31:0] ras_pred;
        logic        ras_hit;
    } res_t;

    typedef struct packed {
        logic        v;
        logic [1:0]  op;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        tk;
        logic        call;
        logic        ret;
        logic        ordy;
    } stim_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'd3;
    logic [31:0] pc = '0;
    logic [31:0] imm = '0;
    logic [31:0] rs1 = '0;
    logic        br_taken = 1'b0;
    logic        is_call = 1'b0;
    logic        is_ret = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] target;
    logic [31:0] link;
    logic        redirect;
    logic        misaligned;
    logic [31:0] ras_pred;
    logic        ras_hit;

    int   vectors = 0;
    int   miscompares = 0;
    res_t sb[$];

    always #5 CLK = ~CLK;

    branch_target_unit #(.XLEN(32), .RAS_DEPTH(4)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .pc         (pc),
        .imm        (imm),
        .rs1        (rs1),
        .br_taken   (br_taken),
        .is_call    (is_call),
        .is_ret     (is_ret),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .target     (target),
        .link       (link),
        .redirect   (redirect),
        .misaligned (misaligned),
        .ras_pred   (ras_pred),
        .ras_hit    (ras_hit)
    );

    function automatic stim_t st(logic v, logic [1:0] o, logic [31:0] p, logic [31:0] i,
                                 logic [31:0] r1, logic tk, logic c, logic rt, logic ordy);
        stim_t s;
        s = '{v: v, op: o, pc: p, imm: i, rs1: r1, tk: tk, call: c, ret: rt, ordy: ordy};
        return s;
    endfunction

    function automatic res_t r(logic [31:0] t, logic [31:0] l, logic rd, logic m,
                               logic [31:0] rp, logic rh);
        res_t x;
        x = '{target: t, link: l, redirect: rd, misaligned: m,
              ras_pred: RAS_ON ? rp : 32'h0, ras_hit: RAS_ON ? rh : 1'b0};
        return x;
    endfunction

    function automatic res_t model(logic [1:0] o, logic [31:0] p, logic [31:0] i,
                                   logic [31:0] r1, logic tk);
        res_t x;
        logic [31:0] s;
        x = '0;
        x.link = p + 32'd4;
        x.target = p + 32'd4;
        if (o == 2'd0 && tk) begin
            x.target = p + i;
            x.redirect = (x.target != x.link);
        end else if (o == 2'd1) begin
            x.target = p + i;
            x.redirect = 1'b1;
        end else if (o == 2'd2) begin
            s = r1 + i;
            x.target = {s[31:1], 1'b0};
            x.redirect = 1'b1;
        end
        x.misaligned = (x.target[1:0] != 2'b00);
        return x;
    endfunction

    task automatic drive(stim_t s);
        in_valid  = s.v;
        op        = s.op;
        pc        = s.pc;
        imm       = s.imm;
        rs1       = s.rs1;
        br_taken  = s.tk;
        is_call   = s.call;
        is_ret    = s.ret;
        out_ready = s.ordy;
    endtask

    task automatic test_reset();
        drive(st(0, NONE, 0, 0, 0, 0, 0, 0, 1));
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready_during got %b exp 1", in_ready);
        end
        vectors++;
        if ({out_valid, target, link, redirect, misaligned, ras_pred, ras_hit} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b t=%h l=%h rd=%b m=%b rp=%h rh=%b exp all 0",
                     out_valid, target, link, redirect, misaligned, ras_pred, ras_hit);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_after got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_jal_jalr();
        stim_t s[$];
        res_t  e[$];
        res_t  got, exp;
        s.push_back(st(1, JAL,  32'h100, 32'h20, 32'h0,    0, 0, 0, 1));
        e.push_back(r(32'h120, 32'h104, 1, 0, 0, 0));
        s.push_back(st(1, JALR, 32'h200, 32'h0,  32'h2003, 0, 0, 0, 1));
        e.push_back(r(32'h2002, 32'h204, 1, 1, 0, 0));
        s.push_back(st(1, JALR, 32'h300, 32'h11, 32'h1000, 0, 0, 0, 1));
        e.push_back(r(32'h1010, 32'h304, 1, 0, 0, 0));
        s.push_back(st(1, JAL,  32'h400, 32'h2,  32'h0,    0, 0, 0, 1));
        e.push_back(r(32'h402, 32'h404, 1, 1, 0, 0));
        repeat (2) begin
            s.push_back(st(0, NONE, 0, 0, 0, 0, 0, 0, 1));
            e.push_back('0);
        end
        for (int i = 0; i < int'(s.size()); i++) begin
            @(negedge CLK);
            drive(s[i]);
            #1;
            if (out_valid && out_ready) begin
                vectors++;
                got = {target, link, redirect, misaligned, ras_pred, ras_hit};
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL jal_jalr unexpected output got %h exp none", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL jal_jalr[%0d] got %h exp %h", i, got, exp);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(e[i]);
        end
        vectors++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL jal_jalr_drain got out_valid=%b pending=%0d exp 0/0", out_valid, sb.size());
        end
    endtask

    task automatic test_branch();
        stim_t s[$];
        res_t  e[$];
        res_t  got, exp;
        s.push_back(st(1, BRANCH, 32'h40, 32'hFFFF_FFF8, 0, 0, 0, 0, 1));
        e.push_back(r(32'h44, 32'h44, 0, 0, 0, 0));
        s.push_back(st(1, BRANCH, 32'h40, 32'hFFFF_FFF8, 0, 1, 0, 0, 1));
        e.push_back(r(32'h38, 32'h44, 1, 0, 0, 0));
        s.push_back(st(1, BRANCH, 32'h80, 32'h4, 0, 1, 0, 0, 1));
        e.push_back(r(32'h84, 32'h84, 0, 0, 0, 0));
        s.push_back(st(1, NONE, 32'h90, 32'h40, 32'h500, 1, 0, 0, 1));
        e.push_back(r(32'h94, 32'h94, 0, 0, 0, 0));
        s.push_back(st(1, JAL, 32'hFFFF_FFFC, 32'h8, 0, 0, 0, 0, 1));
        e.push_back(r(32'h4, 32'h0, 1, 0, 0, 0));
        s.push_back(st(1, BRANCH, 32'hFFFF_FFF0, 32'h12, 0, 1, 0, 0, 1));
        e.push_back(r(32'h2, 32'hFFFF_FFF4, 1, 1, 0, 0));
        repeat (2) begin
            s.push_back(st(0, NONE, 0, 0, 0, 0, 0, 0, 1));
            e.push_back('0);
        end
        for (int i = 0; i < int'(s.size()); i++) begin
            @(negedge CLK);
            drive(s[i]);
            #1;
            if (out_valid && out_ready) begin
                vectors++;
                got = {target, link, redirect, misaligned, ras_pred, ras_hit};
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL branch unexpected output got %h exp none", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL branch[%0d] got %h exp %h", i, got, exp);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(e[i]);
        end
        vectors++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL branch_drain got out_valid=%b pending=%0d exp 0/0", out_valid, sb.size());
        end
    endtask

    task automatic test_back_to_back_stall();
        stim_t s[$];
        res_t  e[$];
        res_t  got, exp;
        s.push_back(st(1, JAL, 32'h1000, 32'h40, 0, 0, 0, 0, 0));
        e.push_back(r(32'h1040, 32'h1004, 1, 0, 0, 0));
        repeat (3) begin
            s.push_back(st(1, JAL, 32'h2000, 32'h80, 0, 0, 0, 0, 0));
            e.push_back(r(32'h2080, 32'h2004, 1, 0, 0, 0));
        end
        s.push_back(st(1, JAL, 32'h2000, 32'h80, 0, 0, 0, 0, 1));
        e.push_back(r(32'h2080, 32'h2004, 1, 0, 0, 0));
        s.push_back(st(1, BRANCH, 32'h3000, 32'h10, 0, 1, 0, 0, 1));
        e.push_back(r(32'h3010, 32'h3004, 1, 0, 0, 0));
        repeat (2) begin
            s.push_back(st(0, NONE, 0, 0, 0, 0, 0, 0, 1));
            e.push_back('0);
        end
        for (int i = 0; i < int'(s.size()); i++) begin
            @(negedge CLK);
            drive(s[i]);
            #1;
            got = {target, link, redirect, misaligned, ras_pred, ras_hit};
            if (out_valid && !out_ready) begin
                vectors++;
                if (in_ready !== 1'b0 || sb.size() == 0 || got !== sb[0]) begin
                    miscompares++;
                    $display("FAIL stall_hold[%0d] got in_ready=%b out=%h exp in_ready=0 out=%h",
                             i, in_ready, got, (sb.size() != 0) ? sb[0] : '0);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL stall unexpected output got %h exp none", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL stall[%0d] got %h exp %h", i, got, exp);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(e[i]);
        end
        vectors++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL stall_drain got out_valid=%b pending=%0d exp 0/0", out_valid, sb.size());
        end
    endtask

    task automatic test_random();
        stim_t s;
        res_t  got, exp;
        for (int i = 0; i < 160; i++) begin
            @(negedge CLK);
            if (i < 150) begin
                s = st($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
                       ($urandom_range(0, 3) == 0) ? 32'h4 : $urandom, $urandom,
                       1'($urandom_range(0, 1)), 0, 0, $urandom_range(0, 3) != 0);
            end else begin
                s = st(0, NONE, 0, 0, 0, 0, 0, 0, 1);
            end
            drive(s);
            #1;
            got = {target, link, redirect, misaligned, ras_pred, ras_hit};
            if (out_valid && !out_ready) begin
                vectors++;
                if (in_ready !== 1'b0 || sb.size() == 0 || got !== sb[0]) begin
                    miscompares++;
                    $display("FAIL random_hold[%0d] got in_ready=%b out=%h exp in_ready=0 out=%h",
                             i, in_ready, got, (sb.size() != 0) ? sb[0] : '0);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL random unexpected output got %h exp none", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL random[%0d] got %h exp %h", i, got, exp);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(s.op, s.pc, s.imm, s.rs1, s.tk));
        end
        vectors++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL random_drain got out_valid=%b pending=%0d exp 0/0", out_valid, sb.size());
        end
    endtask

    task automatic test_ras();
        stim_t s[$];
        res_t  e[$];
        res_t  got, exp;
        logic [31:0] pops[4] = '{32'h44, 32'h34, 32'h24, 32'h14};
        for (int k = 0; k < 5; k++) begin
            s.push_back(st(1, JAL, 32'(k * 16), 32'h100, 0, 0, 1, 0, 1));
            e.push_back(r(32'(k * 16 + 256), 32'(k * 16 + 4), 1, 0, 0, 0));
        end
        s.push_back(st(1, BRANCH, 32'h50, 32'h10, 0, 1, 1, 1, 1));
        e.push_back(r(32'h60, 32'h54, 1, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            s.push_back(st(1, JALR, 32'h200, 32'h0, 32'h300, 0, 0, 1, 1));
            e.push_back(r(32'h300, 32'h204, 1, 0, (k < 4) ? pops[k] : 32'h0, k < 4));
        end
        s.push_back(st(1, JALR, 32'h500, 32'h0, 32'h300, 0, 1, 1, 1));
        e.push_back(r(32'h300, 32'h504, 1, 0, 0, 0));
        s.push_back(st(1, JALR, 32'h600, 32'h0, 32'h300, 0, 1, 1, 1));
        e.push_back(r(32'h300, 32'h604, 1, 0, 32'h504, 1));
        s.push_back(st(1, JALR, 32'h200, 32'h0, 32'h300, 0, 0, 1, 1));
        e.push_back(r(32'h300, 32'h204, 1, 0, 32'h604, 1));
        s.push_back(st(1, JALR, 32'h200, 32'h0, 32'h300, 0, 0, 1, 1));
        e.push_back(r(32'h300, 32'h204, 1, 0, 0, 0));
        repeat (2) begin
            s.push_back(st(0, NONE, 0, 0, 0, 0, 0, 0, 1));
            e.push_back('0);
        end
        for (int i = 0; i < int'(s.size()); i++) begin
            @(negedge CLK);
            drive(s[i]);
            #1;
            if (out_valid && out_ready) begin
                vectors++;
                got = {target, link, redirect, misaligned, ras_pred, ras_hit};
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL ras unexpected output got %h exp none", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL ras[%0d] got %h exp %h", i, got, exp);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(e[i]);
        end

        // Reset while a call result is parked behind out_ready=0.
        @(negedge CLK);
        drive(st(1, JAL, 32'h700, 32'h10, 0, 0, 1, 0, 1));
        @(negedge CLK);
        drive(st(1, JAL, 32'h710, 32'h10, 0, 0, 1, 0, 0));
        @(negedge CLK);
        drive(st(0, NONE, 0, 0, 0, 0, 0, 0, 0));
        #2;
        RST_N = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ras_mid_reset got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
        sb.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        drive(st(1, JALR, 32'h800, 32'h0, 32'h900, 0, 0, 1, 1));
        #1;
        if (in_valid && in_ready) sb.push_back(r(32'h900, 32'h804, 1, 0, 0, 0));
        @(negedge CLK);
        drive(st(0, NONE, 0, 0, 0, 0, 0, 0, 1));
        #1;
        vectors++;
        got = {target, link, redirect, misaligned, ras_pred, ras_hit};
        if (!(out_valid && out_ready) || sb.size() == 0) begin
            miscompares++;
            $display("FAIL ras_after_reset got out_valid=%b pending=%0d exp 1/1", out_valid, sb.size());
        end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
                miscompares++;
                $display("FAIL ras_after_reset got %h exp %h", got, exp);
            end
        end
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_jal_jalr();
        test_branch();
        test_back_to_back_stall();
        test_random();
        test_ras();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
